fetch_unit: RTL and testbench

Instruction fetch stage feeding the decoder and control unit. It owns the fetch PC and issues word requests to instruction memory over a request/grant/response handshake. Fetched words are buffered in a small FIFO and handed to the decode stage with valid/ready. Branch and jump redirects from execute flush everything in flight.

---
 rtl/fetch_unit_pkg.sv | 16 +
 rtl/fetch_unit_buffer.sv | 47 ++++
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared constants and buffer entry type for the instruction fetch stage.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_VAL = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_unit_buffer.sv
// fetchBuffer: synchronous FIFO of fetched {instr, pc} entries with flush.
module fetchBuffer
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  wdata,
    output fetch_entry_t  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;

    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign rdata   = mem[rp];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(do_push);
            rp    <= rp + AW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) mem[wp] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, credit-limited imem requests and redirect discard tracking feeding decode.
// Optional FETCH_PERF_CNT_EN adds fetch_count / stall_count outputs.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_VAL,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc_f, instr_q, pc_q, pcp4_q;
    logic [31:0]   aq [DEPTH];
    logic [AW-1:0] aq_wp, aq_rp;
    logic [CW-1:0] outstanding, discard, occupancy, in_flight;
    logic          grant, push, pop, buf_full, buf_empty;
    fetch_entry_t  head, wentry;

    assign in_flight  = outstanding + CW'(grant) - CW'(imem_rvalid);
    assign imem_addr  = pc_f;
    assign imem_req   = !reset && !PCSrc && (outstanding + occupancy < CW'(DEPTH));
    assign grant      = imem_req && imem_gnt;
    assign push       = imem_rvalid && discard == '0 && !PCSrc && !buf_full;
    assign pop        = inst_valid && inst_ready;
    assign wentry     = '{instr: imem_rdata, pc: aq[aq_rp]};
    assign inst_valid = !buf_empty;
    assign Instr      = buf_empty ? instr_q : head.instr;
    assign PC         = buf_empty ? pc_q : head.pc;
    assign PCPlus4    = buf_empty ? pcp4_q : head.pc + 32'd4;

    fetchBuffer #(.DEPTH(DEPTH)) u_buf (
        .clk   (clk),
        .rst   (reset),
        .push  (push),
        .pop   (pop),
        .flush (PCSrc),
        .wdata (wentry),
        .rdata (head),
        .full  (buf_full),
        .empty (buf_empty),
        .count (occupancy)
    );

    // Addresses of granted requests ride alongside in order, so stale responses still retire theirs.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f        <= word_align(RESET_PC);
            outstanding <= '0;
            discard     <= '0;
            aq_wp       <= '0;
            aq_rp       <= '0;
            instr_q     <= '0;
            pc_q        <= '0;
            pcp4_q      <= '0;
        end else begin
            pc_f        <= PCSrc ? word_align(PCTarget) : grant ? pc_f + 32'd4 : pc_f;
            outstanding <= in_flight;
            discard     <= PCSrc ? in_flight : discard - CW'(imem_rvalid && discard != '0);
            aq_wp       <= aq_wp + AW'(grant);
            aq_rp       <= aq_rp + AW'(imem_rvalid);
            if (pop) begin
                instr_q <= head.instr;
                pc_q    <= head.pc;
                pcp4_q  <= head.pc + 32'd4;
            end
            if (PCSrc) instr_q <= NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (grant && !reset) aq[aq_wp] <= pc_f;
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            fetch_count <= fetch_count + 32'(pop);
            stall_count <= stall_count + 32'(inst_valid && !inst_ready);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit (DEPTH=4) against an in-order latency memory model.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        PCSrc = 1'b0;
    logic [31:0] PCTarget = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] Instr, PC, PCPlus4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, stall_count;
`endif
    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(32'h0), .DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .PCSrc       (PCSrc),
        .PCTarget    (PCTarget),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .Instr       (Instr),
        .PC          (PC),
        .PCPlus4     (PCPlus4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count (fetch_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: word at address a is ~a, returned lat cycles after its grant, in order.
    typedef struct {logic [31:0] addr; int due;} req_t;
    req_t q[$];
    int   cyc = 0;
    int   lat = 1;

    always @(negedge clk) begin
        if (reset) q.delete();
        else begin
            if (imem_rvalid) void'(q.pop_front());
            if (imem_req && imem_gnt) q.push_back('{imem_addr, cyc + lat});
        end
    end

    always @(posedge clk) begin
        #1;
        cyc = reset ? 0 : cyc + 1;
        imem_rvalid = !reset && q.size() > 0 && q[0].due <= cyc;
        imem_rdata  = q.size() > 0 ? ~q[0].addr : '0;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_dut(input int l, input bit rdy);
        lat = l; inst_ready = rdy; PCSrc = 0; PCTarget = '0; imem_gnt = 1; reset = 1;
        repeat (3) tick();
        reset = 0;
    endtask

    task automatic expect_stream(input logic [31:0] start, input int n, input bit strict);
        logic [31:0] e = start;
        int got = 0;
        for (int i = 0; i < 64 && got < n; i++) begin
            @(negedge clk);
            if (strict || inst_valid) begin
                checks++;
                if (inst_valid !== 1'b1 || PC !== e || Instr !== ~e || PCPlus4 !== e + 32'd4) begin
                    errors++;
                    $display("FAIL stream valid=%b pc=%h instr=%h pcplus4=%h expected valid=1 pc=%h instr=%h pcplus4=%h",
                             inst_valid, PC, Instr, PCPlus4, e, ~e, e + 32'd4);
                end
                if (inst_valid) begin
                    e += 32'd4;
                    got++;
                end
            end
        end
        if (got < n) begin
            checks++; errors++;
            $display("FAIL stream_timeout got %0d pops expected %0d from pc=%h", got, n, start);
        end
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) tick();
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b expected 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h expected 00000000", imem_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", inst_valid); end
        checks++; if (Instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h expected 00000000", Instr); end
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL reset_pc got %h expected 00000000", PC); end
        checks++; if (PCPlus4 !== 32'h0) begin errors++; $display("FAIL reset_pcplus4 got %h expected 00000000", PCPlus4); end
    endtask

    task automatic test_stream();
        reset_dut(1, 1);
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_req req=%b addr=%h expected 1 00000000", imem_req, imem_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL early_valid_c0 got %b expected 0", inst_valid); end
        @(negedge clk);
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL second_addr got %h expected 00000004", imem_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL early_valid_c1 got %b expected 0", inst_valid); end
        expect_stream(32'h0, 8, 1);
    endtask

    task automatic test_stall();
        int g = 0;
        reset_dut(1, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (imem_req && imem_gnt) g++;
            if (i >= 2) begin
                checks++;
                if (inst_valid !== 1'b1 || Instr !== 32'hFFFF_FFFF || PC !== 32'h0) begin
                    errors++;
                    $display("FAIL stall_hold valid=%b instr=%h pc=%h expected 1 ffffffff 00000000", inst_valid, Instr, PC);
                end
            end
            tick();
        end
        checks++; if (g != 4) begin errors++; $display("FAIL stall_credits got %0d grants expected 4", g); end
        inst_ready = 1;
        expect_stream(32'h0, 10, 0);
    endtask

    task automatic test_redirect_discard();
        reset_dut(3, 1);
        repeat (3) tick();
        PCSrc = 1; PCTarget = 32'h0000_0103;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redirect_req_block got %b expected 0", imem_req); end
        tick();
        PCSrc = 0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL redirect_target req=%b addr=%h expected 1 00000100", imem_req, imem_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redirect_valid got %b expected 0", inst_valid); end
        expect_stream(32'h100, 4, 0);
    endtask

    task automatic test_same_cycle_redirect();
        reset_dut(1, 1);
        repeat (4) tick();
        PCSrc = 1; PCTarget = 32'h200; inst_ready = 0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL same_cycle_req got %b expected 0", imem_req); end
        tick();
        PCSrc = 0; inst_ready = 1;
        @(negedge clk);
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b expected 0", inst_valid); end
        checks++; if (Instr !== 32'h0000_0013) begin errors++; $display("FAIL flush_nop got %h expected 00000013", Instr); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL same_cycle_target req=%b addr=%h expected 1 00000200", imem_req, imem_addr); end
        @(negedge clk);
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL dropped_rdata valid=%b pc=%h expected valid 0", inst_valid, PC); end
        expect_stream(32'h200, 3, 1);
    endtask

    task automatic test_wrap();
        reset_dut(1, 1);
        PCSrc = 1; PCTarget = 32'hFFFF_FFF8;
        tick();
        PCSrc = 0;
        @(negedge clk);
        checks++; if (imem_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_target got %h expected fffffff8", imem_addr); end
        expect_stream(32'hFFFF_FFF8, 4, 0);
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf_counters();
        reset_dut(1, 1);
        @(negedge clk);
        checks++; if (fetch_count !== 32'd0 || stall_count !== 32'd0) begin errors++; $display("FAIL perf_reset fetch=%0d stall=%0d expected 0 0", fetch_count, stall_count); end
        expect_stream(32'h0, 6, 0);
        tick();
        inst_ready = 0;
        repeat (4) tick();
        inst_ready = 1;
        expect_stream(32'd24, 4, 0);
        tick();
        inst_ready = 0;
        @(negedge clk);
        checks++; if (fetch_count !== 32'd10) begin errors++; $display("FAIL perf_fetch got %0d expected 10", fetch_count); end
        checks++; if (stall_count !== 32'd4) begin errors++; $display("FAIL perf_stall got %0d expected 4", stall_count); end
        inst_ready = 1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_discard();
        test_same_cycle_redirect();
        test_wrap();
`ifdef FETCH_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
